// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, frame constants and bit-period rounding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clocks per bit, rounded to the nearest integer (half rounds up).
    function automatic int bit_cycles(input int clock_freq, input int baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
// Module      : uart_tx_if
// Description : Byte-in / serial-out handshake bundle for the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;

    logic       new_data;
    logic [7:0] dat_i;
    logic       rdy;
    logic       dat_o;

    modport master (
        output new_data,
        output dat_i,
        input  rdy,
        input  dat_o
    );

    modport slave (
        input  new_data,
        input  dat_i,
        output rdy,
        output dat_o
    );

endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// Module      : uart_baud_tick
// Description : Bit-period counter; 1-cycle tick every BIT_CYCLES clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int BIT_CYCLES = 10417
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic clr_i,
    output logic      tick_o
);

    localparam int c_CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIT_CYCLES - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    // The clear lands on the frame-start edge so the first bit gets a full period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == c_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : 8N1 UART transmitter with new_data/rdy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    uart_tx_if.slave  tx
);

    localparam int BIT_CYCLES = bit_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int c_IDX_W    = $clog2(DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic                 dat_o_q, dat_o_d;
    logic                 rdy_q, rdy_d;

    logic                 w_tick;
    logic                 w_accept;

    assign w_accept = tx.new_data & rdy_q;

    uart_baud_tick #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_baud_tick (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_accept),
        .tick_o (w_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        dat_o_d = dat_o_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    shift_d = tx.dat_i;
                    idx_d   = '0;
                    dat_o_d = 1'b0;
                    rdy_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (w_tick) begin
                    dat_o_d = shift_q[0];
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (idx_q == c_LAST_IDX) begin
                        dat_o_d = 1'b1;
                        state_d = STOP;
                    end else begin
                        dat_o_d = shift_q[0];
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    rdy_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                dat_o_d = 1'b1;
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            dat_o_q <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            dat_o_q <= dat_o_d;
            rdy_q   <= rdy_d;
        end
    end

    assign tx.dat_o = dat_o_q;
    assign tx.rdy   = rdy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx at three bit periods.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst [3];
    logic       nd  [3];
    logic [7:0] din [3];
    logic       txo [3];
    logic       rdyo[3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_if u_if0 ();
    uart_tx_if u_if1 ();
    uart_tx_if u_if2 ();

    assign u_if0.new_data = nd[0];
    assign u_if0.dat_i    = din[0];
    assign u_if1.new_data = nd[1];
    assign u_if1.dat_i    = din[1];
    assign u_if2.new_data = nd[2];
    assign u_if2.dat_i    = din[2];
    assign txo[0]  = u_if0.dat_o;
    assign rdyo[0] = u_if0.rdy;
    assign txo[1]  = u_if1.dat_o;
    assign rdyo[1] = u_if1.rdy;
    assign txo[2]  = u_if2.dat_o;
    assign rdyo[2] = u_if2.rdy;

    // 1.25 MHz / 100 kBd = 12.5 -> 13 clocks per bit (exercises round-half-up)
    uart_tx #(.CLOCK_FREQ(1_250_000), .BAUD_RATE(100_000)) u_dut0 (
        .clk_i (clk), .rst_i (rst[0]), .tx (u_if0.slave));
    uart_tx #(.CLOCK_FREQ(16_000_000), .BAUD_RATE(9600)) u_dut1 (
        .clk_i (clk), .rst_i (rst[1]), .tx (u_if1.slave));
    uart_tx u_dut2 (
        .clk_i (clk), .rst_i (rst[2]), .tx (u_if2.slave));

    function automatic int bc_of(input int i);
        case (i)
            0:       return 13;
            1:       return 1667;
            default: return 10417;
        endcase
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[idx];
    endfunction

    // Reference: a frame is 10 bit slots of bc clocks each, starting the cycle after accept.
    bit         m_busy[3];
    int         m_k   [3];
    logic [7:0] m_byte[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                m_busy[i] <= 1'b0;
            end else if (m_busy[i]) begin
                if (m_k[i] == 10 * bc_of(i) - 1) m_busy[i] <= 1'b0;
                else                             m_k[i]    <= m_k[i] + 1;
            end else if (nd[i]) begin
                m_busy[i] <= 1'b1;
                m_k[i]    <= 0;
                m_byte[i] <= din[i];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pulse(input int i, input logic [7:0] b);
        @(negedge clk);
        nd[i]  = 1'b1;
        din[i] = b;
        @(negedge clk);
        nd[i]  = 1'b0;
        din[i] = ~b;
    endtask

    // Called on the first start-bit cycle; samples each slot at its midpoint.
    task automatic capture(input int i, input bit poke, output logic [9:0] f);
        int bc;
        bc = bc_of(i);
        repeat (bc / 2) @(negedge clk);
        f[0] = txo[i];
        for (int j = 1; j < 10; j++) begin
            if (poke && j == 4) begin
                nd[i]  = 1'b1;
                din[i] = 8'hFF;
                @(negedge clk);
                nd[i]  = 1'b0;
                repeat (bc - 1) @(negedge clk);
            end else begin
                repeat (bc) @(negedge clk);
            end
            f[j] = txo[i];
        end
    endtask

    task automatic count_while(input int i, input bit use_rdy, input logic lvl,
                               input int limit, output int n);
        n = 0;
        while (((use_rdy ? rdyo[i] : txo[i]) === lvl) && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (rdyo[i] !== 1'b1 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", {31'd0, rdyo[i]}, 32'd1);
    endtask

    initial begin
        logic [9:0] f;
        int n;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            nd[i]  = 1'b0;
            din[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_dat_o", {31'd0, txo[i]}, 32'd1);
            check("reset_rdy",   {31'd0, rdyo[i]}, 32'd1);
            rst[i] = 1'b0;
        end

        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    logic ed, er;
                    ed = m_busy[i] ? frame_bit(m_byte[i], m_k[i] / bc_of(i)) : 1'b1;
                    er = !m_busy[i];
                    n_checks++;
                    if (txo[i] !== ed || rdyo[i] !== er) begin
                        n_fail++;
                        if (n_fail < 20)
                            $display("FAIL model[%0d]: dat_o=%b rdy=%b expected dat_o=%b rdy=%b (t=%0t)",
                                     i, txo[i], rdyo[i], ed, er, $time);
                    end
                end
            end
        join_none

        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (txo[0] && txo[1] && txo[2]) n++;
        end
        check("idle_line_high", n, 100);

        pulse(0, 8'h27);
        check("accept_rdy_low", {31'd0, rdyo[0]}, 32'd0);
        capture(0, 1'b0, f);
        check("frame_27", {22'd0, f}, {22'd0, 10'b1001001110});
        wait_idle(0);

        pulse(0, 8'h27);
        count_while(0, 1'b1, 1'b0, 1000, n);
        check("rdy_low_len", n, 130);

        for (int b = 8'h27; b <= 8'h2F; b++) begin
            pulse(0, 8'(b));
            capture(0, 1'b0, f);
            check("sweep_frame", {22'd0, f}, {22'd0, 1'b1, 8'(b), 1'b0});
            wait_idle(0);
        end

        pulse(0, 8'h31);
        capture(0, 1'b1, f);
        check("busy_frame_31", {22'd0, f}, {22'd0, 10'b1001100010});
        wait_idle(0);
        n = 0;
        repeat (3 * 13) begin
            @(negedge clk);
            if (rdyo[0] !== 1'b1) n++;
        end
        check("busy_no_second", n, 0);

        @(negedge clk);
        nd[0]  = 1'b1;
        din[0] = 8'h55;
        @(negedge clk);
        count_while(0, 1'b1, 1'b0, 1000, n);
        check("b2b_frame_len", n, 130);
        count_while(0, 1'b1, 1'b1, 1000, n);
        check("b2b_gap", n, 1);
        nd[0] = 1'b0;
        check("b2b_start", {31'd0, txo[0]}, 32'd0);
        repeat (4 * 13 + 13 / 2) @(negedge clk);
        check("b2b_bit3", {31'd0, txo[0]}, 32'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("abort_dat_o", {31'd0, txo[0]}, 32'd1);
        check("abort_rdy",   {31'd0, rdyo[0]}, 32'd1);

        pulse(1, 8'hA5);
        capture(1, 1'b0, f);
        check("frame_a5", {22'd0, f}, {22'd0, 10'b1101001010});
        wait_idle(1);

        pulse(2, 8'h27);
        count_while(2, 1'b0, 1'b0, 20000, n);
        check("default_start_len", n, 10417);
        check("default_bit0", {31'd0, txo[2]}, 32'd1);
        check("default_busy", {31'd0, rdyo[2]}, 32'd0);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        check("default_abort_rdy", {31'd0, rdyo[2]}, 32'd1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
